store_issue_buffer: RTL
=======================

// Module: store_issue_buffer
// PURPOSE
//  Write-side counterpart of the MEM-stage load path. Accepts committed stores (SB/SH/SW/SWL/SWR),
//  aligns data and builds byte strobes, then buffers them in an in-order FIFO.
//  Drains the FIFO to the data-SRAM-like bus via req/addr_ok/data_ok.
//  Sits between the EXE/MEM boundary and the data bus; sb_idle gates younger loads for ordering.
// PARAMETERS
//  SB_DEPTH         4  FIFO entries; power of two, >=2
//  MAX_OUTSTANDING  2  max accepted-address writes awaiting data_ok; >=1
// PORTS
//  clk            in   1   clock
//  resetn         in   1   async active-low reset
//  st_valid       in   1   store request valid
//  st_ready       out  1   FIFO can accept
//  st_op          in   3   0=SB 1=SH 2=SW 3=SWL 4=SWR; 5-7 illegal
//  st_addr        in   32  byte address
//  st_rt          in   32  rt register value
//  flush          in   1   exception flush from WB; blocks acceptance this cycle
//  st_ades        out  1   misaligned-store flag (SB_ADDR_CHECK_EN only; else tied 0)
//  data_req       out  1   bus request
//  data_wr        out  1   constant 1
//  data_size      out  2   0=byte 1=half 2=word
//  data_addr      out  32  bus address
//  data_wstrb     out  4   byte enables
//  data_wdata     out  32  aligned write data
//  data_addr_ok   in   1   request accepted
//  data_data_ok   in   1   write completed
//  sb_idle        out  1   FIFO empty and zero outstanding
// BEHAVIOUR
//  Reset (async, resetn=0): FIFO count/ptrs=0, outstanding=0, data_req=0, st_ready=1, sb_idle=1,
//   st_ades=0. A reset mid-transaction discards all entries; late data_ok after reset is ignored.
//  Push: st_valid && st_ready && !flush && legal op (&& !misaligned when check enabled).
//   st_ready = (count < SB_DEPTH). There is no pass-through when full.
//  Alignment (a = st_addr[1:0], little-endian):
//   SB : size0, addr=st_addr, strb=4'b0001<<a, wdata={4{rt[7:0]}}
//   SH : size1, addr=st_addr, strb=a[1]?1100:0011, wdata={2{rt[15:0]}}
//   SW : size2, addr=st_addr, strb=1111, wdata=rt
//   SWL: size2, addr={addr[31:2],00}, a=0/1/2/3 -> strb 0001/0011/0111/1111, wdata=rt>>(8*(3-a))
//   SWR: size2, addr={addr[31:2],00}, a=0/1/2/3 -> strb 1111/1110/1100/1000, wdata=rt<<(8*a)
//  Entry stores {size,addr,strb,wdata}, computed at push.
//  Issue: data_req = (count!=0) && (outstanding<MAX_OUTSTANDING); head entry drives bus fields.
//   Fields are stable while req is held. Latency: a push into an empty FIFO gives req on the next cycle.
//  Pop: data_req && data_addr_ok -> head ptr++, outstanding++.
//  data_data_ok -> outstanding--. If accept and data_ok occur in the same cycle, outstanding is unchanged.
//   data_data_ok with outstanding==0 is ignored (no underflow).
//  Push and pop in the same cycle: count is unchanged, pointers wrap modulo SB_DEPTH.
//  flush does not drop buffered entries: they are committed and continue draining.
//  sb_idle = (count==0) && (outstanding==0), combinational from registered state.
// CONFIGURATION
//  SB_ADDR_CHECK_EN defined: SH with a[0]!=0 or SW with a!=0 is misaligned.
//   st_ades=1 combinationally with st_valid; the entry is not pushed and st_ready is unaffected.
//   Illegal st_op is also rejected, with st_ades=0.
//  SB_ADDR_CHECK_EN undefined: st_ades tied 0. A misaligned SH uses a[1] only; a misaligned SW
//   forces addr[1:0]=00. Illegal st_op is not pushed.
// TESTING
//  Reset then idle -> data_req=0, sb_idle=1, st_ready=1.
//  SB addr=0x1003 rt=0xAABBCCDD, addr_ok same cycle -> req 1 cycle after push:
//   addr=0x1003, strb=1000, wdata=0xDDDDDDDD, size0.
//  SWL a=1 rt=0x11223344 -> strb 0011, wdata=0x00001122, addr=0x...00;
//   SWR a=2 -> strb 1100, wdata=0x33440000.
//  Push 4 stores with addr_ok=0 -> st_ready=0 after 4th; 5th not taken.
//   Then addr_ok=1 and data_ok delayed -> only 2 pops (MAX_OUTSTANDING) until data_ok.
//  Push on the pop cycle at count=2 -> count stays 2; pointers wrap over 12 ops, order preserved.
//  flush=1 with st_valid -> no push, buffered entries still issue; resetn=0 mid-drain -> req=0 at once.
//  SB_ADDR_CHECK_EN: SW addr=0x1002 -> st_ades=1, no push, sb_idle stays 1.

Source files
------------

// File: rtl/store_issue_buffer.sv
// store_issue_buffer
//   In-order write buffer between the EXE/MEM boundary and the data bus.
//   Committed stores (SB/SH/SW/SWL/SWR) are aligned and given byte strobes
//   at push time. They are then queued and drained over a req/addr_ok/data_ok
//   bus. The number of accepted writes still waiting for data_ok is bounded.
//   sb_idle tells the load path that no store is pending anywhere.
//
//   Optional feature: define SB_ADDR_CHECK_EN to reject misaligned SH/SW and
//   report them on st_ades. In the default build st_ades is tied to 0.
//
// Ports
//   clk, resetn                 clock, async active-low reset
//   st_valid/st_ready           store push handshake
//   st_op, st_addr, st_rt       store opcode (0..4 legal), byte address, rt value
//   flush                       blocks acceptance this cycle only
//   st_ades                     misaligned-store flag
//   data_req/data_addr_ok       bus request handshake (head entry)
//   data_wr, data_size, data_addr, data_wstrb, data_wdata   bus request fields
//   data_data_ok                write completion
//   sb_idle                     FIFO empty and nothing outstanding
module store_issue_buffer #(
  parameter int SB_DEPTH        = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_rt,
  input  logic        flush,
  output logic        st_ades,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  output logic        sb_idle
);

  localparam int PW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int CW = $clog2(SB_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(SB_DEPTH);
  localparam logic [OW-1:0] MAX_C   = OW'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } sb_entry_t;

  sb_entry_t     mem_q [SB_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [OW-1:0] outst_q;

  sb_entry_t     new_e, head_e;
  logic [1:0]    a;
  logic          op_legal, acc_ok, push, pop, dok;

  assign a = st_addr[1:0];

  // Alignment and strobe generation, done once at push time.
  always_comb begin
    new_e    = '0;
    op_legal = 1'b1;
    case (st_op)
      3'd0: begin
        new_e.size  = 2'd0;
        new_e.addr  = st_addr;
        new_e.strb  = 4'b0001 << a;
        new_e.wdata = {4{st_rt[7:0]}};
      end
      3'd1: begin
        // Only a[1] selects the half. A misaligned a[0] is ignored here.
        new_e.size  = 2'd1;
        new_e.addr  = st_addr;
        new_e.strb  = a[1] ? 4'b1100 : 4'b0011;
        new_e.wdata = {2{st_rt[15:0]}};
      end
      3'd2: begin
        new_e.size  = 2'd2;
        new_e.addr  = {st_addr[31:2], 2'b00};
        new_e.strb  = 4'b1111;
        new_e.wdata = st_rt;
      end
      3'd3: begin
        // SWL: the upper bytes of rt land in the low lanes up to byte a.
        new_e.size = 2'd2;
        new_e.addr = {st_addr[31:2], 2'b00};
        case (a)
          2'd0:    begin new_e.strb = 4'b0001; new_e.wdata = {24'd0, st_rt[31:24]}; end
          2'd1:    begin new_e.strb = 4'b0011; new_e.wdata = {16'd0, st_rt[31:16]}; end
          2'd2:    begin new_e.strb = 4'b0111; new_e.wdata = {8'd0,  st_rt[31:8]};  end
          default: begin new_e.strb = 4'b1111; new_e.wdata = st_rt;                 end
        endcase
      end
      3'd4: begin
        // SWR: the lower bytes of rt land from byte a upward.
        new_e.size = 2'd2;
        new_e.addr = {st_addr[31:2], 2'b00};
        new_e.strb = 4'b1111 << a;
        case (a)
          2'd0:    new_e.wdata = st_rt;
          2'd1:    new_e.wdata = {st_rt[23:0], 8'd0};
          2'd2:    new_e.wdata = {st_rt[15:0], 16'd0};
          default: new_e.wdata = {st_rt[7:0],  24'd0};
        endcase
      end
      default: op_legal = 1'b0;
    endcase
  end

`ifdef SB_ADDR_CHECK_EN
  logic misal;
  assign misal   = ((st_op == 3'd1) && a[0]) || ((st_op == 3'd2) && (a != 2'd0));
  assign st_ades = st_valid && misal;
  assign acc_ok  = op_legal && !misal;
`else
  assign st_ades = 1'b0;
  assign acc_ok  = op_legal;
`endif

  assign st_ready = (count_q < DEPTH_C);
  assign push     = st_valid && st_ready && !flush && acc_ok;

  assign head_e   = mem_q[rd_ptr_q];
  assign data_req = (count_q != '0) && (outst_q < MAX_C);
  assign pop      = data_req && data_addr_ok;
  // A data_ok that arrives with nothing outstanding (e.g. after reset) is ignored.
  assign dok      = data_data_ok && (outst_q != '0);

  assign data_wr    = 1'b1;
  assign data_size  = head_e.size;
  assign data_addr  = head_e.addr;
  assign data_wstrb = head_e.strb;
  assign data_wdata = head_e.wdata;

  assign sb_idle = (count_q == '0) && (outst_q == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      outst_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
      case ({pop, dok})
        2'b10:   outst_q <= outst_q + OW'(1);
        2'b01:   outst_q <= outst_q - OW'(1);
        default: ;
      endcase
    end
  end

  // Payload storage needs no reset: count_q qualifies every entry.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_e;
  end

endmodule
